pio_bank: RTL and testbench
===========================

Name: pio_bank

Overview:
- Parametrised general-purpose I/O bank with an Avalon-MM slave. It replaces separate fixed-width button, DIP-switch and LED PIO instances with one block.
- Inputs are synchronised, debounced per channel and edge-captured. Each channel has per-edge enables and can raise a maskable interrupt.
- Outputs come from a data register with atomic set/clear aliases.
- Sits on the HPS lightweight H2F bridge; irq connects to an F2H interrupt line.

Parameters:
- IN_WIDTH, 4: number of input channels (1..32).
- OUT_WIDTH, 8: number of output channels (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept an input change (>=1; 1 = synchroniser only).
- IN_RESET, 0: reset value of the synchroniser and debounced-input registers (IN_WIDTH bits).
- OUT_RESET, 0: reset value of the output data register (OUT_WIDTH bits).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- avs_address  input  3  word address.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data, valid one cycle after avs_read.
- pio_in  input  IN_WIDTH  raw asynchronous inputs (buttons/switches).
- pio_out  output  OUT_WIDTH  registered outputs (LEDs).
- irq  output  1  level interrupt, active-high.

Behaviour:
- Reset: avs_readdata=0, pio_out=OUT_RESET, irq=0. Sync stages and debounced input = IN_RESET. Debounce counters, IRQ_MASK, EDGE_CAP, RISE_EN and FALL_EN = 0.
- Register map (word addresses):
  - 0 DATA_IN: RO, debounced inputs.
  - 1 DATA_OUT: RW.
  - 2 OUT_SET: WO, DATA_OUT |= wdata.
  - 3 OUT_CLR: WO, DATA_OUT &= ~wdata.
  - 4 IRQ_MASK: RW.
  - 5 EDGE_CAP: read, write-1-to-clear.
  - 6 RISE_EN: RW.
  - 7 FALL_EN: RW.
- Width rules: unused upper bits read 0 and writes to them are ignored. Reads of WO addresses return 0.
- Bus timing: no waitrequest. A write takes effect at the clock edge it is presented. avs_readdata is registered with read latency 1 and holds its value when avs_read=0. Simultaneous read and write on the same cycle: the read returns the pre-write value.
- pio_out = DATA_OUT register directly; no combinational path from the bus.
- Input path per channel:
  - Two-flop synchroniser produces s.
  - Counter cnt, width clog2(DEBOUNCE_CYCLES+1).
  - If s == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and is never accepted.
  - Latency from a pio_in change to a DATA_IN change = 2 + DEBOUNCE_CYCLES cycles.
- Edge detect: rise = stable_next & ~stable & RISE_EN; fall = ~stable_next & stable & FALL_EN. EDGE_CAP bit is set on the cycle stable updates.
- EDGE_CAP clear: a bit clears when written with 1. If a new edge and a W1C hit the same bit in the same cycle, set wins. Disabling RISE_EN/FALL_EN does not clear already-captured bits.
- irq is registered: irq <= |(EDGE_CAP_next & IRQ_MASK_next). It follows register changes by 1 cycle.
- Reset asserted mid-operation: all state returns to reset values immediately. Edges in flight are lost. No edge is generated when reset releases.

Test Plan (DEBOUNCE_CYCLES=4, IN_WIDTH=4, OUT_WIDTH=8):
- Reset -> pio_out=0x00, irq=0; read addr 0 returns 0x0, read addr 5 returns 0x0.
- Write 0xA5 to addr 1, then 0x0F to addr 2, then 0x81 to addr 3 -> pio_out=0xA5, then 0xAF, then 0x2E; read addr 1 returns 0x2E.
- pio_in[0] high for 3 cycles then low -> DATA_IN stays 0x0, EDGE_CAP stays 0. Held high continuously -> DATA_IN=0x1 exactly 6 cycles after the change.
- RISE_EN=0x1, IRQ_MASK=0x1, pio_in[0] 0->1 and held -> EDGE_CAP=0x1, irq=1 one cycle later. Write 0x1 to addr 5 -> irq=0.
- FALL_EN=0x4, IRQ_MASK=0: pio_in[2] 1->0 -> EDGE_CAP bit2=1, irq stays 0. Write IRQ_MASK=0x4 -> irq=1 next cycle.
- A W1C of bit0 on the same cycle a new rising edge on bit0 is captured -> EDGE_CAP bit0 remains 1. Assert reset mid-debounce -> cnt=0 and DATA_IN=IN_RESET.

Source files
------------

// File: rtl/pio_bank.sv
// pio_bank: parametrised GPIO bank behind an Avalon-MM slave.
// Raw inputs pass through a two-flop synchroniser and a per-channel debouncer.
// Edges on the debounced value are captured per channel and can raise a maskable
// level interrupt. Outputs come from a data register with atomic set/clear aliases.
module pio_bank #(
    parameter int                   IN_WIDTH        = 4,
    parameter int                   OUT_WIDTH       = 8,
    parameter int                   DEBOUNCE_CYCLES = 50000,
    parameter logic [IN_WIDTH-1:0]  IN_RESET        = '0,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out,
    output logic                 irq
);

    // Counter wide enough to hold DEBOUNCE_CYCLES; acceptance happens when it
    // reaches DEBOUNCE_CYCLES-1 with the synchronised value still differing.
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Word addresses of the register map
    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd2;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

    logic [IN_WIDTH-1:0]  r_sync1;
    logic [IN_WIDTH-1:0]  r_sync2;
    logic [IN_WIDTH-1:0]  r_stable;
    logic [CNT_W-1:0]     r_cnt [IN_WIDTH];
    logic [OUT_WIDTH-1:0] r_dataOut;
    logic [IN_WIDTH-1:0]  r_irqMask;
    logic [IN_WIDTH-1:0]  r_edgeCap;
    logic [IN_WIDTH-1:0]  r_riseEn;
    logic [IN_WIDTH-1:0]  r_fallEn;
    logic [31:0]          r_readData;
    logic                 r_irq;

    logic [IN_WIDTH-1:0]  w_stableNext;
    logic [CNT_W-1:0]     w_cntNext [IN_WIDTH];
    logic [IN_WIDTH-1:0]  w_rise;
    logic [IN_WIDTH-1:0]  w_fall;
    logic [IN_WIDTH-1:0]  w_edgeNext;
    logic [IN_WIDTH-1:0]  w_maskNext;
    logic [OUT_WIDTH-1:0] w_dataOutNext;
    logic [31:0]          w_readMux;
    logic [IN_WIDTH-1:0]  w_wdIn;
    logic [OUT_WIDTH-1:0] w_wdOut;
    logic                 w_wrDataOut;
    logic                 w_wrOutSet;
    logic                 w_wrOutClr;
    logic                 w_wrIrqMask;
    logic                 w_wrEdgeCap;
    logic                 w_wrRiseEn;
    logic                 w_wrFallEn;
    logic                 w_unusedWriteData;

    // Bus write decode; only the implemented low bits of the write data are used.
    assign w_wdIn      = avs_writedata[IN_WIDTH-1:0];
    assign w_wdOut     = avs_writedata[OUT_WIDTH-1:0];
    assign w_wrDataOut = avs_write && (avs_address == ADDR_DATA_OUT);
    assign w_wrOutSet  = avs_write && (avs_address == ADDR_OUT_SET);
    assign w_wrOutClr  = avs_write && (avs_address == ADDR_OUT_CLR);
    assign w_wrIrqMask = avs_write && (avs_address == ADDR_IRQ_MASK);
    assign w_wrEdgeCap = avs_write && (avs_address == ADDR_EDGE_CAP);
    assign w_wrRiseEn  = avs_write && (avs_address == ADDR_RISE_EN);
    assign w_wrFallEn  = avs_write && (avs_address == ADDR_FALL_EN);
    assign w_unusedWriteData = ^avs_writedata;

    // Two-flop synchroniser for the asynchronous raw inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= IN_RESET;
            r_sync2 <= IN_RESET;
        end else begin
            r_sync1 <= pio_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a channel accepts a new value only after it differed from the
    // stable value for DEBOUNCE_CYCLES consecutive cycles; any return to the
    // stable value restarts the count, so short glitches are never accepted.
    always_comb begin
        w_stableNext = r_stable;
        for (int i = 0; i < IN_WIDTH; i++) begin
            w_cntNext[i] = r_cnt[i];
            if (r_sync2[i] == r_stable[i]) begin
                w_cntNext[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_stableNext[i] = r_sync2[i];
                w_cntNext[i]    = '0;
            end else begin
                w_cntNext[i] = r_cnt[i] + CNT_ONE;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= IN_RESET;
            for (int i = 0; i < IN_WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stableNext;
            for (int i = 0; i < IN_WIDTH; i++) begin
                r_cnt[i] <= w_cntNext[i];
            end
        end
    end

    // Edge capture next value: W1C clears first, then newly detected edges are
    // OR-ed in so a same-cycle edge beats the clear.
    always_comb begin
        w_rise     = w_stableNext & ~r_stable & r_riseEn;
        w_fall     = ~w_stableNext & r_stable & r_fallEn;
        w_edgeNext = r_edgeCap;
        if (w_wrEdgeCap) begin
            w_edgeNext = w_edgeNext & ~w_wdIn;
        end
        w_edgeNext = w_edgeNext | w_rise | w_fall;
        w_maskNext = w_wrIrqMask ? w_wdIn : r_irqMask;
    end

    // Output data register next value with plain write and set/clear aliases
    always_comb begin
        w_dataOutNext = r_dataOut;
        if (w_wrDataOut) begin
            w_dataOutNext = w_wdOut;
        end else if (w_wrOutSet) begin
            w_dataOutNext = r_dataOut | w_wdOut;
        end else if (w_wrOutClr) begin
            w_dataOutNext = r_dataOut & ~w_wdOut;
        end
    end

    // Control/status registers and the registered interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dataOut <= OUT_RESET;
            r_irqMask <= '0;
            r_edgeCap <= '0;
            r_riseEn  <= '0;
            r_fallEn  <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_dataOut <= w_dataOutNext;
            r_irqMask <= w_maskNext;
            r_edgeCap <= w_edgeNext;
            if (w_wrRiseEn) begin
                r_riseEn <= w_wdIn;
            end
            if (w_wrFallEn) begin
                r_fallEn <= w_wdIn;
            end
            r_irq <= |(w_edgeNext & w_maskNext);
        end
    end

    // Read mux built from current register values, so a same-cycle write is
    // not visible to the read; write-only aliases read back as zero.
    always_comb begin
        w_readMux = '0;
        case (avs_address)
            ADDR_DATA_IN:  w_readMux = 32'(r_stable);
            ADDR_DATA_OUT: w_readMux = 32'(r_dataOut);
            ADDR_IRQ_MASK: w_readMux = 32'(r_irqMask);
            ADDR_EDGE_CAP: w_readMux = 32'(r_edgeCap);
            ADDR_RISE_EN:  w_readMux = 32'(r_riseEn);
            ADDR_FALL_EN:  w_readMux = 32'(r_fallEn);
            default:       w_readMux = '0;
        endcase
    end

    // Read data register: latency one, holds its value between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readData <= '0;
        end else if (avs_read) begin
            r_readData <= w_readMux;
        end
    end

    assign avs_readdata = r_readData;
    assign pio_out      = r_dataOut;
    assign irq          = r_irq;

endmodule

// File: tb/tb_pio_bank.sv
// tb_pio_bank: directed self-checking bench for pio_bank with a short debounce.
// A table of bus vectors covers the register map, followed by hand-written
// sequences for debounce timing, edge capture, interrupts and reset.
module tb_pio_bank;

    logic        clk;
    logic        reset;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [3:0]  pio_in;
    logic [7:0]  pio_out;
    logic        irq;

    int checks;
    int errors;

    typedef struct {
        logic        isWrite;
        logic        isRead;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] expRd;
        logic [7:0]  expOut;
        logic        expIrq;
    } vec_t;

    vec_t vecs [19];

    pio_bank #(
        .IN_WIDTH        (4),
        .OUT_WIDTH       (8),
        .DEBOUNCE_CYCLES (4),
        .IN_RESET        (4'h0),
        .OUT_RESET       (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .pio_in        (pio_in),
        .pio_out       (pio_out),
        .irq           (irq)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value and report a mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive on the falling edge, sample 1 time unit after the rising edge
    task automatic applyStimulus(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_write     = w;
        avs_read      = r;
        avs_address   = a;
        avs_writedata = d;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        avs_read  = 1'b0;
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b0, a, d);
    endtask

    task automatic busReadCheck(input string name, input logic [2:0] a, input logic [31:0] exp);
        applyStimulus(1'b0, 1'b1, a, 32'h0);
        checkOutput(name, avs_readdata, exp);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        avs_address   = 3'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        pio_in        = 4'h0;

        //                 wr    rd    addr  wdata          expRd   expOut expIrq
        vecs[0]  = '{1'b1, 1'b0, 3'd1, 32'h0000_00A5, 32'h0,  8'hA5, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd2, 32'h0000_000F, 32'h0,  8'hAF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'd3, 32'h0000_0081, 32'h0,  8'h2E, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd1, 32'h0,         32'h2E, 8'h2E, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd2, 32'h0,         32'h0,  8'h2E, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'd3, 32'h0,         32'h0,  8'h2E, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd4, 32'hFFFF_FFFF, 32'h0,  8'h2E, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'd4, 32'h0,         32'hF,  8'h2E, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd4, 32'h0,         32'h0,  8'h2E, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'd4, 32'h0,         32'h0,  8'h2E, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd6, 32'hFFFF_FFF1, 32'h0,  8'h2E, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'd6, 32'h0,         32'h1,  8'h2E, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'd7, 32'h0000_0004, 32'h0,  8'h2E, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 3'd7, 32'h0,         32'h4,  8'h2E, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'd6, 32'h0,         32'h0,  8'h2E, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 3'd7, 32'h0,         32'h0,  8'h2E, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 3'd1, 32'hFFFF_FF00, 32'h0,  8'h00, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 3'd1, 32'h0,         32'h0,  8'h00, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 3'd0, 32'h0,         32'h0,  8'h00, 1'b0};

        // Reset state, checked while reset is still asserted
        #12;
        checkOutput("reset pio_out", 32'(pio_out), 32'h00);
        checkOutput("reset irq", 32'(irq), 32'h0);
        checkOutput("reset readdata", avs_readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        busReadCheck("reset DATA_IN", 3'd0, 32'h0);
        busReadCheck("reset EDGE_CAP", 3'd5, 32'h0);

        // Register map vectors
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].isWrite, vecs[i].isRead, vecs[i].addr, vecs[i].data);
            if (vecs[i].isRead) begin
                checkOutput($sformatf("vec%0d readdata", i), avs_readdata, vecs[i].expRd);
            end
            checkOutput($sformatf("vec%0d pio_out", i), 32'(pio_out), 32'(vecs[i].expOut));
            checkOutput($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].expIrq));
        end

        // Simultaneous read and write returns the pre-write value; readdata holds after
        busWrite(3'd1, 32'h3C);
        applyStimulus(1'b1, 1'b1, 3'd1, 32'h55);
        checkOutput("rw same cycle readdata", avs_readdata, 32'h3C);
        checkOutput("rw same cycle pio_out", 32'(pio_out), 32'h55);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0);
        checkOutput("readdata hold", avs_readdata, 32'h3C);

        // Glitch of 3 cycles on bit 0 is rejected
        @(negedge clk);
        pio_in = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        pio_in = 4'b0000;
        waitCycles(10);
        busReadCheck("glitch DATA_IN", 3'd0, 32'h0);
        busReadCheck("glitch EDGE_CAP", 3'd5, 32'h0);

        // Held change: DATA_IN updates at the 6th edge, seen on readdata at the 7th
        @(negedge clk);
        pio_in      = 4'b0001;
        avs_address = 3'd0;
        avs_read    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("latency edge%0d", k), avs_readdata, (k >= 7) ? 32'h1 : 32'h0);
        end
        avs_read = 1'b0;
        @(negedge clk);
        pio_in = 4'b0000;
        waitCycles(10);
        busReadCheck("no enables EDGE_CAP", 3'd5, 32'h0);

        // Rising edge capture with interrupt enabled
        busWrite(3'd6, 32'h1);
        busWrite(3'd4, 32'h1);
        @(negedge clk);
        pio_in      = 4'b0001;
        avs_address = 3'd5;
        avs_read    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rise irq edge%0d", k), 32'(irq), (k >= 6) ? 32'h1 : 32'h0);
            checkOutput($sformatf("rise cap edge%0d", k), avs_readdata, (k >= 7) ? 32'h1 : 32'h0);
        end
        avs_read = 1'b0;
        busWrite(3'd5, 32'h1);
        checkOutput("w1c irq", 32'(irq), 32'h0);
        busReadCheck("w1c EDGE_CAP", 3'd5, 32'h0);

        // Falling edge on bit 2 with the interrupt masked, then unmasked
        @(negedge clk);
        pio_in = 4'b0101;
        waitCycles(10);
        busReadCheck("bit2 rise ignored", 3'd5, 32'h0);
        busWrite(3'd4, 32'h0);
        busWrite(3'd7, 32'h4);
        @(negedge clk);
        pio_in = 4'b0001;
        waitCycles(10);
        busReadCheck("fall EDGE_CAP", 3'd5, 32'h4);
        checkOutput("fall masked irq", 32'(irq), 32'h0);
        busWrite(3'd4, 32'h4);
        checkOutput("unmask irq", 32'(irq), 32'h1);
        busWrite(3'd5, 32'h4);
        checkOutput("fall clear irq", 32'(irq), 32'h0);

        // W1C on the same cycle a rising edge on bit 0 is captured: set wins
        @(negedge clk);
        pio_in = 4'b0000;
        waitCycles(10);
        busReadCheck("pre-collision EDGE_CAP", 3'd5, 32'h0);
        @(negedge clk);
        pio_in = 4'b0001;
        repeat (5) @(posedge clk);
        busWrite(3'd5, 32'h1);
        busReadCheck("collision EDGE_CAP", 3'd5, 32'h1);
        busWrite(3'd6, 32'h0);
        busReadCheck("disable keeps EDGE_CAP", 3'd5, 32'h1);
        checkOutput("unmasked bit0 irq", 32'(irq), 32'h0);

        // Reset in the middle of debouncing bit 1
        busWrite(3'd1, 32'h5A);
        @(negedge clk);
        pio_in = 4'b0011;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset pio_out", 32'(pio_out), 32'h00);
        checkOutput("midreset irq", 32'(irq), 32'h0);
        checkOutput("midreset readdata", avs_readdata, 32'h0);
        @(negedge clk);
        reset       = 1'b0;
        avs_address = 3'd0;
        avs_read    = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("post-reset DATA_IN edge%0d", k), avs_readdata, (k >= 7) ? 32'h3 : 32'h0);
        end
        avs_read = 1'b0;
        busReadCheck("post-reset EDGE_CAP", 3'd5, 32'h0);
        checkOutput("post-reset irq", 32'(irq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
